// File: rtl/poci_serializer.sv
// poci_serializer: shifts the addressed register out MSB-first on serial_out, paced by
// edges of an oversampled sclk, auto-incrementing the address after each word.
module poci_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int STOP_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iclk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  addr_valid,
    input  logic [DATA_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] read_addr,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  byte_done
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(STOP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(STOP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [BW-1:0]          bit_cnt;
    logic [IW-1:0]          idle_cnt;
    logic                   sclk_s;
    logic                   rise;
    logic                   fall;
    logic                   sclk_edge;
    logic                   restart;
    logic                   timeout;

    assign sclk_s    = sync_q[SYNC_STAGES-1];
    assign rise      = sclk_s & ~hist;
    assign fall      = ~sclk_s & hist;
    assign sclk_edge = rise | fall;
    // Address 0 is the receiver's "awaiting address" value, never a real start.
    assign restart   = addr_valid && (addr_in != '0);
    assign timeout   = (state != IDLE) && !sclk_edge && (idle_cnt == IDLE_MAX);

    always_ff @(posedge iclk) begin
        if (rst) begin
            state      <= IDLE;
            sync_q     <= '0;
            hist       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            read_addr  <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sclk};
            hist      <= sclk_s;
            byte_done <= 1'b0;
            if (restart) begin
                read_addr <= addr_in;
                bit_cnt   <= '0;
                idle_cnt  <= '0;
                busy      <= 1'b1;
                state     <= LOAD;
            end else if (timeout) begin
                serial_out <= 1'b0;
                idle_cnt   <= '0;
                busy       <= 1'b0;
                state      <= IDLE;
            end else begin
                if (state != IDLE)
                    idle_cnt <= sclk_edge ? '0 : (idle_cnt == IDLE_MAX ? idle_cnt : idle_cnt + 1'b1);
                case (state)
                    IDLE: begin
                        serial_out <= 1'b0;
                        busy       <= 1'b0;
                    end
                    LOAD: begin
                        serial_out <= read_data[DATA_WIDTH-1];
                        shreg      <= read_data << 1;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                    SHIFT: begin
                        // The controller samples on rise, so data only advances on fall.
                        if (fall) begin
                            if (bit_cnt == BIT_LAST) begin
                                byte_done <= 1'b1;
                                read_addr <= read_addr + 1'b1;
                                state     <= LOAD;
                            end else begin
                                serial_out <= shreg[DATA_WIDTH-1];
                                shreg      <= shreg << 1;
                                bit_cnt    <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_poci_serializer.sv
// tb_poci_serializer: drives an sclk controller model against the serializer and
// scoreboards each shifted word against the expected readback values.
module tb_poci_serializer;
    localparam int DW = 8;
    localparam int SC = 8;
    localparam int H  = 5;

    logic          iclk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          addr_valid;
    logic [DW-1:0] addr_in;
    logic [DW-1:0] read_data;
    logic [DW-1:0] read_addr;
    logic [DW-1:0] key;
    logic          serial_out;
    logic          busy;
    logic          byte_done;

    int            n_cmp = 0;
    int            n_err = 0;
    int            bd_cnt = 0;
    logic [DW-1:0] exp_q[$];

    always #5 iclk = ~iclk;

    // Readback mux model: each register holds its address xor a per-test key.
    assign read_data = read_addr ^ key;

    always @(posedge iclk) if (byte_done === 1'b1) bd_cnt <= bd_cnt + 1;

    poci_serializer #(.DATA_WIDTH(DW), .STOP_CYCLES(SC), .SYNC_STAGES(2)) dut (
        .iclk(iclk),
        .rst(rst),
        .sclk(sclk),
        .addr_valid(addr_valid),
        .addr_in(addr_in),
        .read_data(read_data),
        .read_addr(read_addr),
        .serial_out(serial_out),
        .busy(busy),
        .byte_done(byte_done)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge iclk);
    endtask

    // One sclk period; the controller samples serial_out as it raises sclk.
    task automatic sclk_bit(output logic b);
        b = serial_out;
        sclk = 1'b1;
        tick(H);
        sclk = 1'b0;
        tick(H);
    endtask

    task automatic start(input logic [DW-1:0] a);
        addr_in = a;
        addr_valid = 1'b1;
        tick(1);
        addr_valid = 1'b0;
        addr_in = '0;
        tick(1);
    endtask

    task automatic push_bytes(input logic [DW-1:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(DW'(a + DW'(i)) ^ key);
    endtask

    task automatic run_bytes(input int n, input string nm);
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        logic b;
        for (int i = 0; i < n; i++) begin
            got = '0;
            for (int j = 0; j < DW; j++) begin
                sclk_bit(b);
                got = {got[DW-2:0], b};
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s byte %0d: got %h, scoreboard empty", nm, i, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL %s byte %0d: got %h want %h", nm, i, got, want);
                end
            end
        end
    endtask

    task automatic skip_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) sclk_bit(b);
    endtask

    task automatic test_reset;
        rst = 1'b1; sclk = 1'b0; addr_valid = 1'b0; addr_in = '0; key = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL reset_sout: got %b want 0", serial_out); end
        n_cmp++; if (read_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", read_addr); end
        n_cmp++; if (byte_done !== 1'b0) begin n_err++; $display("FAIL reset_bd: got %b want 0", byte_done); end
    endtask

    task automatic test_reset_mid;
        int bd0;
        key = 8'hA0;
        bd0 = bd_cnt;
        start(8'h12);
        skip_bits(3);
        n_cmp++; if (read_addr !== 8'h12) begin n_err++; $display("FAIL midrst_pre_addr: got %h want 12", read_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL midrst_sout: got %b want 0", serial_out); end
        n_cmp++; if (read_addr !== 8'h00) begin n_err++; $display("FAIL midrst_addr: got %h want 00", read_addr); end
        n_cmp++; if (bd_cnt - bd0 !== 0) begin n_err++; $display("FAIL midrst_bd: got %0d want 0", bd_cnt - bd0); end
        tick(4);
    endtask

    task automatic test_basic;
        int bd0;
        key = 8'hA0;
        bd0 = bd_cnt;
        start(8'h05);
        push_bytes(8'h05, 1);
        run_bytes(1, "basic");
        n_cmp++; if (read_addr !== 8'h06) begin n_err++; $display("FAIL basic_addr: got %h want 06", read_addr); end
        n_cmp++; if (bd_cnt - bd0 !== 1) begin n_err++; $display("FAIL basic_bd: got %0d want 1", bd_cnt - bd0); end
        tick(20);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_burst;
        int bd0;
        key = 8'hFF;
        bd0 = bd_cnt;
        start(8'h10);
        push_bytes(8'h10, 3);
        run_bytes(3, "burst");
        n_cmp++; if (read_addr !== 8'h13) begin n_err++; $display("FAIL burst_addr: got %h want 13", read_addr); end
        n_cmp++; if (bd_cnt - bd0 !== 3) begin n_err++; $display("FAIL burst_bd: got %0d want 3", bd_cnt - bd0); end
        tick(20);
    endtask

    task automatic test_wrap;
        int bd0;
        key = 8'hA0;
        bd0 = bd_cnt;
        start(8'hFF);
        push_bytes(8'hFF, 2);
        run_bytes(2, "wrap");
        n_cmp++; if (read_addr !== 8'h01) begin n_err++; $display("FAIL wrap_addr: got %h want 01", read_addr); end
        n_cmp++; if (bd_cnt - bd0 !== 2) begin n_err++; $display("FAIL wrap_bd: got %0d want 2", bd_cnt - bd0); end
        tick(20);
    endtask

    task automatic test_timeout;
        int bd0;
        key = 8'hA0;
        bd0 = bd_cnt;
        start(8'h40);
        skip_bits(4);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL to_pre_busy: got %b want 1", busy); end
        tick(SC + 6);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy: got %b want 0", busy); end
        n_cmp++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL to_sout: got %b want 0", serial_out); end
        n_cmp++; if (read_addr !== 8'h40) begin n_err++; $display("FAIL to_addr: got %h want 40", read_addr); end
        n_cmp++; if (bd_cnt - bd0 !== 0) begin n_err++; $display("FAIL to_bd: got %0d want 0", bd_cnt - bd0); end
        start(8'h00);
        tick(2);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_addr_busy: got %b want 0", busy); end
        n_cmp++; if (read_addr !== 8'h40) begin n_err++; $display("FAIL zero_addr_addr: got %h want 40", read_addr); end
    endtask

    task automatic test_restart;
        int bd0;
        key = 8'h5A;
        bd0 = bd_cnt;
        start(8'h20);
        skip_bits(5);
        start(8'h30);
        n_cmp++; if (bd_cnt - bd0 !== 0) begin n_err++; $display("FAIL rs_abort_bd: got %0d want 0", bd_cnt - bd0); end
        n_cmp++; if (read_addr !== 8'h30) begin n_err++; $display("FAIL rs_addr_load: got %h want 30", read_addr); end
        push_bytes(8'h30, 1);
        run_bytes(1, "restart");
        n_cmp++; if (bd_cnt - bd0 !== 1) begin n_err++; $display("FAIL rs_bd: got %0d want 1", bd_cnt - bd0); end
        n_cmp++; if (read_addr !== 8'h31) begin n_err++; $display("FAIL rs_addr: got %h want 31", read_addr); end
        tick(20);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_burst();
        test_wrap();
        test_timeout();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
